color_cache_loader: RTL and testbench

//  Sequencer that fills the color cache (16-bit word writes at 3-bit addresses, SH commit pulse)

---
 rtl/color_cache_pkg.sv | 17 +
 rtl/color_cache_loader.sv | 165 ++++++++++++++++
 tb/tb_color_cache_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/color_cache_pkg.sv
// Shared types and widths for the color cache loader.
package color_cache_pkg;

  localparam int CC_WORD_W = 16;
  localparam int CC_ADDR_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_COMMIT = 3'd4,
    S_HOLD   = 3'd5,
    S_FIN    = 3'd6
  } ccl_state_t;

endpackage

// File: rtl/color_cache_loader.sv
// Fills the color cache one window at a time from word-addressed memory and hands each
// committed window to the filter datapath through a valid/ack handshake.
module color_cache_loader
  import color_cache_pkg::*;
#(
  parameter int NWORDS      = 6,
  parameter int STRIDE      = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [31:0]          i_base_addr,
  input  logic [15:0]          i_num_windows,
  output logic                 o_mem_rd_en,
  output logic [31:0]          o_mem_addr,
  input  logic [CC_WORD_W-1:0] i_mem_rdata,
  input  logic                 i_mem_valid,
  output logic                 o_cache_we,
  output logic [CC_ADDR_W-1:0] o_cache_addr,
  output logic [CC_WORD_W-1:0] o_cache_di,
  output logic                 o_cache_sh,
  output logic                 o_win_valid,
  input  logic                 i_win_ack,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  ccl_state_t           r_state, w_state_nxt;
  logic [31:0]          r_base, w_base_nxt;
  logic [15:0]          r_num, w_num_nxt;
  logic [15:0]          r_cnt, w_cnt_nxt;
  logic [CC_ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic                 r_err, w_err_nxt;

  logic                 r_mem_rd_en;
  logic [31:0]          r_mem_addr;
  logic                 r_cache_we;
  logic [CC_ADDR_W-1:0] r_cache_addr;
  logic [CC_WORD_W-1:0] r_cache_di;
  logic                 r_cache_sh;
  logic                 r_win_valid;
  logic                 r_busy;
  logic                 r_done;

  // Next-state and counter update logic
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_num_nxt   = r_num;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_base_nxt  = i_base_addr;
          w_num_nxt   = i_num_windows;
          w_cnt_nxt   = 16'd0;
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = (i_num_windows == 16'd0) ? S_FIN : S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_valid) begin
          w_state_nxt = S_WRITE;
        end else if (r_timer == TW'(MEM_TIMEOUT - 1)) begin
          // Memory never answered: abandon the run without writing or committing.
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FIN;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_WRITE: begin
        if (r_idx == CC_ADDR_W'(NWORDS - 1)) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_idx_nxt   = r_idx + CC_ADDR_W'(1);
          w_state_nxt = S_REQ;
        end
      end
      S_COMMIT: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (i_win_ack) begin
          w_cnt_nxt = r_cnt + 16'd1;
          w_idx_nxt = '0;
          if (16'(r_cnt + 16'd1) == r_num) begin
            w_state_nxt = S_FIN;
          end else begin
            w_base_nxt  = r_base + 32'(STRIDE);
            w_state_nxt = S_REQ;
          end
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so they stay registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_base       <= 32'd0;
      r_num        <= 16'd0;
      r_cnt        <= 16'd0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_cache_we   <= 1'b0;
      r_cache_addr <= '0;
      r_cache_di   <= '0;
      r_cache_sh   <= 1'b0;
      r_win_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_base       <= w_base_nxt;
      r_num        <= w_num_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_timer      <= w_timer_nxt;
      r_err        <= w_err_nxt;
      r_mem_rd_en  <= (w_state_nxt == S_REQ);
      r_mem_addr   <= (w_state_nxt == S_REQ) ? (w_base_nxt + 32'(w_idx_nxt)) : 32'd0;
      r_cache_we   <= (w_state_nxt == S_WRITE);
      r_cache_addr <= (w_state_nxt == S_WRITE) ? w_idx_nxt : '0;
      r_cache_di   <= (w_state_nxt == S_WRITE) ? i_mem_rdata : '0;
      r_cache_sh   <= (w_state_nxt == S_COMMIT);
      r_win_valid  <= (w_state_nxt == S_HOLD);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_FIN);
    end
  end

  assign o_mem_rd_en  = r_mem_rd_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_cache_we   = r_cache_we;
  assign o_cache_addr = r_cache_addr;
  assign o_cache_di   = r_cache_di;
  assign o_cache_sh   = r_cache_sh;
  assign o_win_valid  = r_win_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_color_cache_loader.sv
// Randomized self-checking bench for color_cache_loader against a transaction-level model.
module tb_color_cache_loader;

  localparam int NW = 6;
  localparam int ST = 6;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_mem_valid, i_win_ack;
  logic [31:0] i_base_addr;
  logic [15:0] i_num_windows, i_mem_rdata;
  logic        o_mem_rd_en, o_cache_we, o_cache_sh, o_win_valid, o_busy, o_done, o_err;
  logic [31:0] o_mem_addr;
  logic [2:0]  o_cache_addr;
  logic [15:0] o_cache_di;

  color_cache_loader dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_windows(i_num_windows), .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid), .o_cache_we(o_cache_we),
    .o_cache_addr(o_cache_addr), .o_cache_di(o_cache_di), .o_cache_sh(o_cache_sh),
    .o_win_valid(o_win_valid), .i_win_ack(i_win_ack), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tbl [0:5] = '{16'hFAFD, 16'hAABB, 16'h9918, 16'h7744, 16'h33CC, 16'h1155};

  // responder / monitor state
  int          cyc = 0, lat = 1, ack_delay = 1, withhold_k = 0, rd_seen = 0, mem_cnt = 0;
  bit          pend = 0, noise = 0, stray = 0;
  logic [31:0] pend_addr;
  logic [31:0] rd_q [$];
  logic [18:0] wr_q [$];
  int          sh_cnt, done_cnt, wv_cnt, busy_cnt, both_cnt, multi_out, hold_cnt;
  int          first_sh, rd_k_cyc, done_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h100;
    if (off < 32'd6) return tbl[off[2:0]];
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({o_mem_rd_en, o_mem_addr, o_cache_we, o_cache_addr, o_cache_di,
                o_cache_sh, o_win_valid, o_busy, o_done, o_err});
  endfunction

  task automatic clear_mon();
    rd_q.delete(); wr_q.delete();
    sh_cnt = 0; done_cnt = 0; wv_cnt = 0; busy_cnt = 0; both_cnt = 0; multi_out = 0;
    hold_cnt = 0; first_sh = -1; rd_k_cyc = -1; done_cyc = -1; rd_seen = 0; pend = 0;
  endtask

  // One clock: observe outputs at the falling edge, then drive memory, consumer and noise.
  task automatic step();
    @(negedge clk);
    cyc++;
    i_mem_valid = 1'b0;
    if (pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        i_mem_valid = 1'b1;
        i_mem_rdata = mem_fn(pend_addr);
        pend = 0;
      end
    end else if (stray || (noise && o_win_valid)) begin
      i_mem_valid = 1'b1;
      i_mem_rdata = 16'($urandom);
    end
    if (o_mem_rd_en) begin
      if (pend) multi_out++;
      rd_q.push_back(o_mem_addr);
      rd_seen++;
      if (rd_seen == withhold_k) rd_k_cyc = cyc;
      else begin pend = 1; mem_cnt = lat; pend_addr = o_mem_addr; end
    end
    if (o_cache_we) wr_q.push_back({o_cache_addr, o_cache_di});
    if (o_cache_we && o_cache_sh) both_cnt++;
    if (o_cache_sh) begin sh_cnt++; if (first_sh < 0) first_sh = cyc; end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_busy) busy_cnt++;
    if (o_win_valid) begin
      wv_cnt++; hold_cnt++;
      i_win_ack = (hold_cnt >= ack_delay);
    end else begin
      hold_cnt = 0; i_win_ack = 1'b0;
    end
    if (noise) begin
      i_start       = o_busy && ($urandom_range(0, 5) == 0);
      i_base_addr   = $urandom;
      i_num_windows = 16'($urandom);
    end
  endtask

  task automatic run_job(input logic [31:0] base, input logic [15:0] num, input int lt,
                         input int ad, input int wk, input bit nz);
    int s, n_rd, n_wr, n_win;
    logic [31:0] ea;
    clear_mon();
    lat = lt; ack_delay = ad; withhold_k = wk; noise = 0;
    i_base_addr = base; i_num_windows = num; i_start = 1'b1;
    step();
    s = cyc;
    i_start = 1'b0;
    noise = nz;
    check_eq("err_clr", 64'(o_err), 64'd0);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
    if (done_cnt == 0) check_eq("done_timeout", 64'd0, 64'd1);
    noise = 0; i_start = 1'b0;
    step(); step();
    n_rd  = (wk != 0) ? wk : int'(num) * NW;
    n_wr  = (wk != 0) ? wk - 1 : int'(num) * NW;
    n_win = n_wr / NW;
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    check_eq("idle_after", 64'(o_busy), 64'd0);
    check_eq("err", 64'(o_err), 64'((wk != 0) ? 1 : 0));
    check_eq("rd_count", 64'(rd_q.size()), 64'(n_rd));
    for (int j = 0; j < n_rd && j < rd_q.size(); j++) begin
      ea = base + 32'((j / NW) * ST) + 32'(j % NW);
      check_eq("rd_addr", 64'(rd_q[j]), 64'(ea));
    end
    check_eq("wr_count", 64'(wr_q.size()), 64'(n_wr));
    for (int j = 0; j < n_wr && j < wr_q.size(); j++) begin
      ea = base + 32'((j / NW) * ST) + 32'(j % NW);
      check_eq("wr_addr_data", 64'(wr_q[j]), 64'({3'(j % NW), mem_fn(ea)}));
    end
    check_eq("sh_count", 64'(sh_cnt), 64'(n_win));
    check_eq("win_valid_cycles", 64'(wv_cnt), 64'(n_win * ad));
    check_eq("we_sh_excl", 64'(both_cnt), 64'd0);
    check_eq("one_outstanding", 64'(multi_out), 64'd0);
    if (num == 16'd0) check_eq("num0_busy", 64'(busy_cnt), 64'd1);
    if (lt == 1 && n_win > 0) check_eq("sh_cycle", 64'(first_sh - s + 1), 64'd19);
    if (wk != 0) check_eq("timeout_cycles", 64'(done_cyc - rd_k_cyc), 64'd256);
  endtask

  initial begin
    int nm, wk;
    i_rst = 1'b1; i_start = 1'b0; i_mem_valid = 1'b0; i_win_ack = 1'b0;
    i_base_addr = 32'd0; i_num_windows = 16'd0; i_mem_rdata = 16'd0;
    clear_mon();
    repeat (3) step();
    check_eq("reset_state", all_outs(), 64'd0);
    i_rst = 1'b0;
    step();

    run_job(32'h100, 16'd1, 1, 1, 0, 1'b0);
    run_job(32'h100, 16'd3, 1, 5, 0, 1'b0);
    run_job(32'h200, 16'd0, 1, 1, 0, 1'b0);
    run_job(32'h100, 16'd2, 1, 2, 3, 1'b0);
    run_job(32'h100, 16'd1, 2, 1, 0, 1'b0);
    run_job(32'h300, 16'd3, 2, 3, 0, 1'b1);
    run_job(32'hFFFF_FFFC, 16'd2, 1, 2, 0, 1'b0);

    // reset while waiting on memory, then stray read data while idle
    clear_mon();
    lat = 3; ack_delay = 2; withhold_k = 0;
    i_base_addr = 32'h400; i_num_windows = 16'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    check_eq("rst_wait", all_outs(), 64'd0);
    i_rst = 1'b0; pend = 0; rd_q.delete(); stray = 1;
    repeat (4) step();
    stray = 0;
    check_eq("stray_no_rd", 64'(rd_q.size()), 64'd0);
    check_eq("stray_idle", 64'(o_busy), 64'd0);
    check_eq("rst_no_sh", 64'(sh_cnt), 64'd0);

    // reset while holding a committed window
    clear_mon();
    lat = 1; ack_delay = 50;
    i_base_addr = 32'h500; i_num_windows = 16'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 200 && !o_win_valid; k++) step();
    check_eq("hold_reached", 64'(o_win_valid), 64'd1);
    i_rst = 1'b1;
    step();
    check_eq("rst_hold", all_outs(), 64'd0);
    i_rst = 1'b0; pend = 0;
    step();
    check_eq("rst_hold_idle", all_outs(), 64'd0);

    for (int r = 0; r < 6; r++) begin
      nm = $urandom_range(1, 3);
      wk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nm * NW) : 0;
      run_job($urandom, 16'(nm), $urandom_range(1, 3), $urandom_range(1, 6), wk,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
